// File: rtl/uiudp_tx_arbiter.sv
// Round-robin arbiter that shares one uiudp_tx user write port among CH_NUM senders.
// One grant per packet; the granted channel's bytes pass straight through while the packet is open.
module uiudp_tx_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   I_W_udp_clk,
  input  logic                   I_reset_n,
  input  logic [CH_NUM-1:0]      I_ch_req,
  input  logic [16*CH_NUM-1:0]   I_ch_len,
  input  logic [16*CH_NUM-1:0]   I_ch_dest_port,
  input  logic [CH_NUM-1:0]      I_ch_valid,
  input  logic [8*CH_NUM-1:0]    I_ch_data,
  output logic [CH_NUM-1:0]      O_ch_grant,
  output logic [CH_NUM-1:0]      O_ch_busy,
  output logic                   O_W_udp_req,
  output logic [15:0]            O_W_udp_len,
  output logic [15:0]            O_udp_dest_port,
  output logic                   O_W_udp_valid,
  output logic [7:0]             O_W_udp_data,
  input  logic                   I_W_udp_busy,
  output logic [2:0]             O_grant_id,
  output logic                   O_timeout,
  output logic                   O_abort
);

  localparam int WW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [WW-1:0]     WAIT_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]        CH_N4     = 4'(CH_NUM);
  localparam logic [CH_NUM-1:0] ONE_HOT0  = {{(CH_NUM-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_ptr;
  logic [2:0]        r_id;
  logic [15:0]       r_len;
  logic [15:0]       r_dest;
  logic [CH_NUM-1:0] r_grant;
  logic              r_req;
  logic [15:0]       r_cnt;
  logic [WW-1:0]     r_wait;
  logic              r_timeout;
  logic              r_abort;

  logic [15:0]       w_req_ext;
  logic [7:0]        w_valid_ext;
  logic [63:0]       w_data_ext;
  logic [127:0]      w_len_ext;
  logic [127:0]      w_dest_ext;
  logic [3:0]        w_idx;
  logic              w_any;
  logic [2:0]        w_win;
  logic              w_fwd;
  logic              w_beat;
  logic [15:0]       w_cnt_nxt;
  logic              w_done;

  // Widen the per-channel buses to fixed sizes so any channel index selects cleanly.
  assign w_req_ext   = 16'(I_ch_req);
  assign w_valid_ext = 8'(I_ch_valid);
  assign w_data_ext  = 64'(I_ch_data);
  assign w_len_ext   = 128'(I_ch_len);
  assign w_dest_ext  = 128'(I_ch_dest_port);

  // Winner search: scan from farthest to nearest so the channel right after r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = 3'd0;
    w_idx = 4'd0;
    for (int i = CH_NUM; i >= 1; i--) begin
      w_idx = {1'b0, r_ptr} + 4'(i);
      if (w_idx >= CH_N4) begin
        w_idx = w_idx - CH_N4;
      end else begin
        w_idx = w_idx;
      end
      if (w_req_ext[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx[2:0];
      end else begin
        w_any = w_any;
      end
    end
  end

  // Data path: bytes past the latched length never reach the shared port.
  always_comb begin
    w_fwd     = (r_state == S_XFER) && (r_cnt < r_len);
    w_beat    = w_fwd & w_valid_ext[r_id];
    w_cnt_nxt = r_cnt + {15'd0, w_beat};
    w_done    = (w_cnt_nxt == r_len);
  end

  assign O_W_udp_valid   = w_beat;
  assign O_W_udp_data    = w_fwd ? w_data_ext[{r_id, 3'b000} +: 8] : 8'h00;
  assign O_ch_busy       = r_grant & {CH_NUM{I_W_udp_busy}};
  assign O_ch_grant      = r_grant;
  assign O_W_udp_req     = r_req;
  assign O_W_udp_len     = r_len;
  assign O_udp_dest_port = r_dest;
  assign O_grant_id      = r_id;
  assign O_timeout       = r_timeout;
  assign O_abort         = r_abort;

  // Packet FSM: grant, handshake with uiudp_tx, count bytes, release.
  always_ff @(posedge I_W_udp_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 3'(CH_NUM - 1);
      r_id      <= 3'd0;
      r_len     <= 16'd0;
      r_dest    <= 16'd0;
      r_grant   <= {CH_NUM{1'b0}};
      r_req     <= 1'b0;
      r_cnt     <= 16'd0;
      r_wait    <= {WW{1'b0}};
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_win;
            r_len   <= w_len_ext[{w_win, 4'b0000} +: 16];
            r_dest  <= w_dest_ext[{w_win, 4'b0000} +: 16];
            r_grant <= ONE_HOT0 << w_win;
            r_req   <= 1'b1;
            r_wait  <= {WW{1'b0}};
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // Acceptance wins over a timeout landing in the same cycle.
          if (I_W_udp_busy) begin
            r_req   <= 1'b0;
            r_cnt   <= 16'd0;
            r_state <= S_XFER;
          end else if (r_wait == WAIT_LAST) begin
            r_req     <= 1'b0;
            r_grant   <= {CH_NUM{1'b0}};
            r_timeout <= 1'b1;
            r_ptr     <= r_id;
            r_state   <= S_IDLE;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_XFER: begin
          r_cnt <= w_cnt_nxt;
          if (w_done) begin
            r_state <= S_REL;
          end else if (!I_W_udp_busy) begin
            r_abort <= 1'b1;
            r_state <= S_REL;
          end
        end
        S_REL: begin
          if (!I_W_udp_busy) begin
            r_grant <= {CH_NUM{1'b0}};
            r_ptr   <= r_id;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_grant <= {CH_NUM{1'b0}};
        end
      endcase
    end
  end

endmodule
